store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 87 ++++++++
 tb/tb_store_buffer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: in-order circular store buffer that drains to data memory and stalls loads that hit a pending store word
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [1:0]                 st_size,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_wdata,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_addr,
  input  logic                       drain_en,
  output logic                       stall,
  output logic                       dmem_we,
  output logic [31:0]                dmem_wa,
  output logic [31:0]                dmem_wd,
  output logic [1:0]                 dmem_store,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [1:0]    size_q [DEPTH];
  logic [1:0]    size_d [DEPTH];
  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, hit;
  assign empty = count_q == '0;
  assign full  = count_q == CW'(DEPTH);
  assign count = count_q;
  assign push  = st_valid && !full;
  assign pop   = !empty && drain_en;
  always_comb begin
    size_d  = size_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (pop) valid_d[head_q] = 1'b0;
    if (push) begin
      size_d[tail_q]  = (st_size == 2'b11) ? 2'b00 : st_size;
      addr_d[tail_q]  = st_addr;
      data_d[tail_q]  = st_wdata;
      valid_d[tail_q] = 1'b1;
    end
    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + AW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  // word-granular match against every pending store; no forwarding, the load just waits
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      hit = hit | (valid_q[i] && addr_q[i][31:2] == ld_addr[31:2]);
  end
  always_comb begin
    stall      = st_valid ? full : (ld_valid && hit);
    dmem_we    = pop;
    dmem_wa    = empty ? '0 : addr_q[head_q];
    dmem_wd    = empty ? '0 : data_q[head_q];
    dmem_store = empty ? '0 : size_q[head_q];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    size_q <= size_d;
    addr_q <= addr_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench; a reference queue predicts every drained store, count/flags and stall
module tb_store_buffer;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic [1:0]  st_size = '0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_wdata = '0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        drain_en = 1'b0;
  logic        stall, dmem_we, empty, full;
  logic [31:0] dmem_wa, dmem_wd;
  logic [1:0]  dmem_store;
  logic [$clog2(DEPTH):0] count;
  typedef struct packed {
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   armed = 1'b0;
  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_size(st_size), .st_addr(st_addr),
    .st_wdata(st_wdata), .ld_valid(ld_valid), .ld_addr(ld_addr), .drain_en(drain_en),
    .stall(stall), .dmem_we(dmem_we), .dmem_wa(dmem_wa), .dmem_wd(dmem_wd),
    .dmem_store(dmem_store), .count(count), .empty(empty), .full(full)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // reference model: checked and advanced at negedge, modelling the coming rising edge
  always @(negedge clk) begin
    int   n;
    logic hz;
    ent_t h;
    if (rst) sb.delete();
    else if (armed) begin
      n  = sb.size();
      hz = 1'b0;
      foreach (sb[i]) if (sb[i].a[31:2] == ld_addr[31:2]) hz = 1'b1;
      chk("count", 32'(count), n);
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("stall", 32'(stall), 32'(st_valid ? (n == DEPTH) : (ld_valid && hz)));
      chk("dmem_we", 32'(dmem_we), 32'(n > 0 && drain_en));
      if (n == 0) begin
        chk("idle_wa", dmem_wa, 0);
        chk("idle_wd", dmem_wd, 0);
        chk("idle_store", 32'(dmem_store), 0);
      end else begin
        h = sb[0];
        chk("head_wa", dmem_wa, h.a);
        chk("head_wd", dmem_wd, h.d);
        chk("head_store", 32'(dmem_store), 32'(h.sz));
      end
      if (n > 0 && drain_en) void'(sb.pop_front());
      if (st_valid && n < DEPTH)
        sb.push_back({(st_size == 2'b11) ? 2'b00 : st_size, st_addr, st_wdata});
    end
  end
  task automatic cyc(input logic sv, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                     input logic lv, input logic [31:0] la, input logic de, input logic r);
    st_valid = sv; st_size = sz; st_addr = a; st_wdata = d;
    ld_valid = lv; ld_addr = la; drain_en = de; rst = r;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input logic de, input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 2'b00, 0, 0, 1'b0, 0, de, 1'b0);
  endtask
  initial begin
    cyc(1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 1'b1);
    armed = 1'b1;
    idle(1'b0, 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_stall", 32'(stall), 0);
    // single store, held, then drained
    cyc(1'b1, 2'b00, 32'h100, 32'hDEADBEEF, 1'b0, 0, 1'b0, 1'b0);
    idle(1'b0, 1);
    chk("sw_count", 32'(count), 1);
    chk("sw_wa", dmem_wa, 32'h100);
    chk("sw_wd", dmem_wd, 32'hDEADBEEF);
    chk("sw_we_off", 32'(dmem_we), 0);
    idle(1'b1, 1);
    chk("sw_empty", 32'(empty), 1);
    // fill, overflow stall, then drain in order
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'b00, 32'(i * 4), 32'h1000 + 32'(i), 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 32'h10, 32'h5555, 1'b0, 0, 1'b0, 1'b0);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_stall", 32'(stall), 1);
    cyc(1'b1, 2'b00, 32'h10, 32'h5555, 1'b0, 0, 1'b1, 1'b0);
    cyc(1'b1, 2'b00, 32'h10, 32'h5555, 1'b0, 0, 1'b1, 1'b0);
    idle(1'b1, 6);
    chk("ovf_drained", 32'(empty), 1);
    // load hazard on a byte store
    cyc(1'b1, 2'b10, 32'h203, 32'hAB, 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 0, 0, 1'b1, 32'h200, 1'b0, 1'b0);
    chk("hz_stall", 32'(stall), 1);
    cyc(1'b0, 2'b00, 0, 0, 1'b1, 32'h204, 1'b0, 1'b0);
    chk("hz_other", 32'(stall), 0);
    cyc(1'b0, 2'b00, 0, 0, 1'b1, 32'h200, 1'b1, 1'b0);
    cyc(1'b0, 2'b00, 0, 0, 1'b1, 32'h200, 1'b0, 1'b0);
    chk("hz_clear", 32'(stall), 0);
    // steady push+pop wraps pointers
    cyc(1'b1, 2'b01, 32'h400, 32'hA0, 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 32'h404, 32'hA1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 2'b00, 32'h500 + 32'(i * 4), 32'hB0 + 32'(i), 1'b0, 0, 1'b1, 1'b0);
    idle(1'b0, 1);
    chk("wrap_count", 32'(count), 2);
    idle(1'b1, 3);
    // reset mid-operation beats push and pop
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b00, 32'h600 + 32'(i * 4), 32'hC0 + 32'(i), 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 32'h700, 32'hEE, 1'b0, 0, 1'b1, 1'b1);
    idle(1'b1, 1);
    chk("rst_mid_count", 32'(count), 0);
    chk("rst_mid_we", 32'(dmem_we), 0);
    idle(1'b1, 3);
    // illegal size maps to word
    cyc(1'b1, 2'b11, 32'h300, 32'h77, 1'b0, 0, 1'b0, 1'b0);
    idle(1'b0, 1);
    chk("sz11_store", 32'(dmem_store), 0);
    idle(1'b1, 1);
    // random traffic over a small address window
    for (int i = 0; i < 300; i++) begin
      logic sv, lv;
      sv = ($urandom_range(0, 2) == 0);
      lv = ($urandom_range(0, 2) == 0);
      cyc(sv, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 31)), $urandom, lv,
          32'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 60) == 0));
    end
    idle(1'b1, DEPTH + 2);
    chk("final_empty", 32'(empty), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
